// File: rtl/bxu_io_hub_if.sv
// Core-side io handshake of the bxu io hub: channel select, input (RX) path
// towards the core and output (TX) path from the core.
interface bxu_io_hub_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int CH_BITWIDTH   = 1
);
  logic [CH_BITWIDTH-1:0]   io_ch_sel;
  logic [DATA_BITWIDTH-1:0] io_input_data;
  logic                     io_input_ready;
  logic                     io_input_done;
  logic [DATA_BITWIDTH-1:0] io_output_data;
  logic                     io_output_ready;
  logic                     io_output_done;

  // The core drives selection, consumption and outgoing bytes.
  modport master (
    output io_ch_sel,
    output io_input_done,
    output io_output_data,
    output io_output_ready,
    input  io_input_data,
    input  io_input_ready,
    input  io_output_done
  );

  // The hub presents RX heads and acknowledges accepted bytes.
  modport slave (
    input  io_ch_sel,
    input  io_input_done,
    input  io_output_data,
    input  io_output_ready,
    output io_input_data,
    output io_input_ready,
    output io_output_done
  );
endinterface

// File: rtl/bxu_io_hub.sv
// Multi-channel byte buffer between the bxu core io handshake and CHANNELS
// external byte-stream devices. Each channel owns an RX FIFO (device to core)
// and a TX FIFO (core to device). The core handshake pops on the rising edge
// of io_input_done only, and pushes through a lockout FSM so a level-holding
// core is accepted exactly once per io_output_ready assertion.
module bxu_io_hub #(
  parameter int DATA_BITWIDTH = 8,
  parameter int CHANNELS      = 2,
  parameter int CH_BITWIDTH   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  bxu_io_hub_if.slave                       io,
  input  logic [CHANNELS-1:0]               rx_valid,
  input  logic [CHANNELS*DATA_BITWIDTH-1:0] rx_data,
  output logic [CHANNELS-1:0]               rx_ready,
  output logic [CHANNELS-1:0]               tx_valid,
  output logic [CHANNELS*DATA_BITWIDTH-1:0] tx_data,
  input  logic [CHANNELS-1:0]               tx_ready,
  output logic [CHANNELS-1:0]               rx_empty,
  output logic [CHANNELS-1:0]               tx_full
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DONE,
    WAIT_LOW
  } out_state_t;

  out_state_t state_q, state_d;

  logic [DATA_BITWIDTH-1:0] rx_mem [CHANNELS][FIFO_DEPTH];
  logic [DATA_BITWIDTH-1:0] tx_mem [CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]         rx_wr_ptr [CHANNELS];
  logic [PTR_W-1:0]         rx_rd_ptr [CHANNELS];
  logic [PTR_W-1:0]         tx_wr_ptr [CHANNELS];
  logic [PTR_W-1:0]         tx_rd_ptr [CHANNELS];
  logic [CNT_W-1:0]         rx_count  [CHANNELS];
  logic [CNT_W-1:0]         tx_count  [CHANNELS];

  logic                     done_prev;
  logic [CHANNELS-1:0]      sel_onehot;
  logic                     sel_valid;
  logic [DATA_BITWIDTH-1:0] sel_rx_head;
  logic                     sel_rx_nonempty;
  logic                     sel_tx_full;
  logic                     core_pop;
  logic                     accept;
  logic                     out_done;
  logic [CHANNELS-1:0]      rx_push, rx_pop, tx_push, tx_pop;

  // Per-channel status, forced to the idle pattern while reset is held.
  always_comb begin
    rx_ready = '0;
    rx_empty = '1;
    tx_valid = '0;
    tx_full  = '0;
    tx_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rx_ready[i] = !rst && (rx_count[i] != FULL_CNT);
      rx_empty[i] = rst || (rx_count[i] == '0);
      tx_valid[i] = !rst && (tx_count[i] != '0);
      tx_full[i]  = !rst && (tx_count[i] == FULL_CNT);
      tx_data[i*DATA_BITWIDTH +: DATA_BITWIDTH] = tx_mem[i][tx_rd_ptr[i]];
    end
  end

  // Decode io_ch_sel; an out-of-range select matches no channel at all.
  always_comb begin
    sel_onehot      = '0;
    sel_rx_head     = '0;
    sel_rx_nonempty = 1'b0;
    sel_tx_full     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (io.io_ch_sel == CH_BITWIDTH'(i)) begin
        sel_onehot[i]   = 1'b1;
        sel_rx_head     = rx_mem[i][rx_rd_ptr[i]];
        sel_rx_nonempty = (rx_count[i] != '0);
        sel_tx_full     = (tx_count[i] == FULL_CNT);
      end
    end
  end

  assign sel_valid         = |sel_onehot;
  assign io.io_input_ready = !rst && sel_rx_nonempty;
  assign io.io_input_data  = sel_rx_head;
  assign io.io_output_done = out_done;

  assign core_pop = io.io_input_done && !done_prev && io.io_input_ready;
  assign accept   = (state_q == IDLE) && io.io_output_ready && sel_valid && !sel_tx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = core_pop ? sel_onehot : '0;
  assign tx_push  = accept ? sel_onehot : '0;
  assign tx_pop   = tx_valid & tx_ready;

  // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rx_wr_ptr[i] <= '0;
        rx_rd_ptr[i] <= '0;
        tx_wr_ptr[i] <= '0;
        tx_rd_ptr[i] <= '0;
        rx_count[i]  <= '0;
        tx_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rx_push[i]) rx_wr_ptr[i] <= rx_wr_ptr[i] + PTR_W'(1);
        if (rx_pop[i])  rx_rd_ptr[i] <= rx_rd_ptr[i] + PTR_W'(1);
        if (tx_push[i]) tx_wr_ptr[i] <= tx_wr_ptr[i] + PTR_W'(1);
        if (tx_pop[i])  tx_rd_ptr[i] <= tx_rd_ptr[i] + PTR_W'(1);
        if (rx_push[i] && !rx_pop[i]) rx_count[i] <= rx_count[i] + CNT_W'(1);
        if (!rx_push[i] && rx_pop[i]) rx_count[i] <= rx_count[i] - CNT_W'(1);
        if (tx_push[i] && !tx_pop[i]) tx_count[i] <= tx_count[i] + CNT_W'(1);
        if (!tx_push[i] && tx_pop[i]) tx_count[i] <= tx_count[i] - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rx_push[i]) rx_mem[i][rx_wr_ptr[i]] <= rx_data[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      if (tx_push[i]) tx_mem[i][tx_wr_ptr[i]] <= io.io_output_data;
    end
  end

  // Remember last io_input_done level and advance the output FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
      state_q   <= IDLE;
    end else begin
      done_prev <= io.io_input_done;
      state_q   <= state_d;
    end
  end

  // Output FSM: accept once, pulse done, then wait for the core to drop ready.
  always_comb begin
    state_d  = state_q;
    out_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DONE;
      end
      DONE: begin
        out_done = !rst;
        state_d  = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!io.io_output_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bxu_io_hub.sv
// Self-checking bench for bxu_io_hub: a queue-based model of the hub is
// compared against the DUT every cycle, and directed scenarios add literal
// expectations at the interesting points.
module tb_bxu_io_hub;
  localparam int DW    = 8;
  localparam int N_CH  = 2;
  localparam int CHW   = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   rx_valid, rx_ready, tx_valid, tx_ready, rx_empty, tx_full;
  logic [N_CH*DW-1:0] rx_data, tx_data;

  bxu_io_hub_if #(.DATA_BITWIDTH(DW), .CH_BITWIDTH(CHW)) io_bus ();

  bxu_io_hub #(
    .DATA_BITWIDTH(DW),
    .CHANNELS     (N_CH),
    .CH_BITWIDTH  (CHW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (io_bus),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_empty(rx_empty),
    .tx_full (tx_full)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: plain queues per channel plus the core-handshake memory.
  logic [DW-1:0]   rx_model [N_CH][$];
  logic [DW-1:0]   tx_model [N_CH][$];
  bit              prev_done   = 1'b0;
  bit              rearmed     = 1'b1;
  bit              exp_done    = 1'b0;
  bit              cmp_en      = 1'b0;
  int              edge_cnt    = 0;
  int              accept_edge = 0;
  int              sel_idx;
  bit              sel_ok, do_pop, do_accept;
  bit [N_CH-1:0]   m_rx_push, m_tx_pop;
  logic [N_CH-1:0] exp_rx_ready, exp_rx_empty, exp_tx_valid, exp_tx_full;
  logic [DW-1:0]   exp_list [4];
  int              done_cnt;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model update on every rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        rx_model[ch].delete();
        tx_model[ch].delete();
      end
      prev_done = 1'b0;
      rearmed   = 1'b1;
      exp_done  = 1'b0;
    end else begin
      sel_ok    = (io_bus.io_ch_sel < N_CH);
      sel_idx   = int'(io_bus.io_ch_sel);
      do_pop    = 1'b0;
      do_accept = 1'b0;
      if (sel_ok) begin
        do_pop    = io_bus.io_input_done && !prev_done && (rx_model[sel_idx].size() > 0);
        do_accept = rearmed && io_bus.io_output_ready && (tx_model[sel_idx].size() < DEPTH);
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        m_rx_push[ch] = rx_valid[ch] && (rx_model[ch].size() < DEPTH);
        m_tx_pop[ch]  = tx_ready[ch] && (tx_model[ch].size() > 0);
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        if (m_tx_pop[ch])  void'(tx_model[ch].pop_front());
        if (m_rx_push[ch]) rx_model[ch].push_back(rx_data[ch*DW +: DW]);
      end
      if (do_pop)    void'(rx_model[sel_idx].pop_front());
      if (do_accept) tx_model[sel_idx].push_back(io_bus.io_output_data);
      if (!rearmed && (edge_cnt >= accept_edge + 2) && !io_bus.io_output_ready) rearmed = 1'b1;
      if (do_accept) begin
        rearmed     = 1'b0;
        accept_edge = edge_cnt;
      end
      exp_done  = do_accept;
      prev_done = io_bus.io_input_done;
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        exp_rx_ready[ch] = !rst && (rx_model[ch].size() < DEPTH);
        exp_rx_empty[ch] = rst || (rx_model[ch].size() == 0);
        exp_tx_valid[ch] = !rst && (tx_model[ch].size() > 0);
        exp_tx_full[ch]  = !rst && (tx_model[ch].size() == DEPTH);
      end
      checkOutput("rx_ready", 32'(rx_ready), 32'(exp_rx_ready));
      checkOutput("rx_empty", 32'(rx_empty), 32'(exp_rx_empty));
      checkOutput("tx_valid", 32'(tx_valid), 32'(exp_tx_valid));
      checkOutput("tx_full", 32'(tx_full), 32'(exp_tx_full));
      checkOutput("io_output_done", 32'(io_bus.io_output_done), 32'(!rst && exp_done));
      for (int ch = 0; ch < N_CH; ch++) begin
        if (exp_tx_valid[ch]) checkOutput("tx_data", 32'(tx_data[ch*DW +: DW]), 32'(tx_model[ch][0]));
      end
      if (!rst && (io_bus.io_ch_sel < N_CH)) begin
        sel_idx = int'(io_bus.io_ch_sel);
        checkOutput("io_input_ready", 32'(io_bus.io_input_ready), 32'(rx_model[sel_idx].size() > 0));
        if (rx_model[sel_idx].size() > 0)
          checkOutput("io_input_data", 32'(io_bus.io_input_data), 32'(rx_model[sel_idx][0]));
      end else begin
        checkOutput("io_input_ready", 32'(io_bus.io_input_ready), 32'd0);
      end
    end
  end

  initial begin
    rst                    = 1'b1;
    rx_valid               = '0;
    rx_data                = '0;
    tx_ready               = '0;
    io_bus.io_ch_sel       = '0;
    io_bus.io_input_done   = 1'b0;
    io_bus.io_output_data  = '0;
    io_bus.io_output_ready = 1'b0;

    // Reset values while rst is held, then the first cycle after release.
    applyStimulus(2);
    cmp_en = 1'b1;
    checkOutput("reset rx_ready", 32'(rx_ready), 32'h0);
    checkOutput("reset rx_empty", 32'(rx_empty), 32'h3);
    checkOutput("reset done", 32'(io_bus.io_output_done), 32'h0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("release rx_ready", 32'(rx_ready), 32'h3);

    // Two bytes into RX ch0; a held io_input_done pops exactly once.
    rx_valid = 2'b01;
    rx_data  = 16'h0011;
    applyStimulus(1);
    checkOutput("rx0 ready after push", 32'(io_bus.io_input_ready), 32'h1);
    checkOutput("rx0 head 11", 32'(io_bus.io_input_data), 32'h11);
    rx_data = 16'h0022;
    applyStimulus(1);
    rx_valid = 2'b00;
    checkOutput("rx0 head still 11", 32'(io_bus.io_input_data), 32'h11);
    io_bus.io_input_done = 1'b1;
    applyStimulus(3);
    checkOutput("held done pops once", 32'(io_bus.io_input_data), 32'h22);
    io_bus.io_input_done = 1'b0;
    applyStimulus(1);
    io_bus.io_input_done = 1'b1;
    applyStimulus(1);
    checkOutput("rx0 drained", 32'(io_bus.io_input_ready), 32'h0);
    io_bus.io_input_done = 1'b0;
    applyStimulus(1);

    // Fill RX ch1, block a fifth byte, then free one slot and wrap pointers.
    io_bus.io_ch_sel = 2'd1;
    rx_valid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      rx_data = {8'(8'hA0 + k), 8'h00};
      applyStimulus(1);
    end
    checkOutput("rx1 full", 32'(rx_ready[1]), 32'h0);
    rx_data = 16'hA400;
    applyStimulus(2);
    checkOutput("rx1 still full", 32'(rx_ready[1]), 32'h0);
    checkOutput("rx1 head A0", 32'(io_bus.io_input_data), 32'hA0);
    io_bus.io_input_done = 1'b1;
    applyStimulus(1);
    checkOutput("rx1 space freed", 32'(rx_ready[1]), 32'h1);
    checkOutput("rx1 head A1", 32'(io_bus.io_input_data), 32'hA1);
    io_bus.io_input_done = 1'b0;
    applyStimulus(1);
    rx_valid = 2'b00;
    checkOutput("rx1 A4 entered", 32'(rx_ready[1]), 32'h0);
    exp_list = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int k = 0; k < 4; k++) begin
      checkOutput("rx1 drain order", 32'(io_bus.io_input_data), 32'(exp_list[k]));
      io_bus.io_input_done = 1'b1;
      applyStimulus(1);
      io_bus.io_input_done = 1'b0;
      applyStimulus(1);
    end
    checkOutput("rx1 empty", 32'(io_bus.io_input_ready), 32'h0);

    // Core sends 0x5A on ch1 holding ready for six cycles: one done pulse.
    io_bus.io_output_data  = 8'h5A;
    io_bus.io_output_ready = 1'b1;
    applyStimulus(1);
    checkOutput("out done pulse", 32'(io_bus.io_output_done), 32'h1);
    checkOutput("out tx_valid", 32'(tx_valid), 32'h2);
    checkOutput("out tx_data 5A", 32'(tx_data[15:8]), 32'h5A);
    done_cnt = 1;
    io_bus.io_output_data = 8'h99;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      done_cnt += int'(io_bus.io_output_done);
    end
    checkOutput("single done pulse", 32'(done_cnt), 32'd1);
    io_bus.io_output_ready = 1'b0;
    applyStimulus(1);
    tx_ready = 2'b10;
    applyStimulus(1);
    tx_ready = 2'b00;
    checkOutput("tx1 drained", 32'(tx_valid), 32'h0);

    // Fill TX ch0, then offer 0x77 with no room until the device takes one.
    io_bus.io_ch_sel = 2'd0;
    for (int k = 0; k < 4; k++) begin
      io_bus.io_output_data  = 8'(8'h70 + k);
      io_bus.io_output_ready = 1'b1;
      applyStimulus(1);
      io_bus.io_output_ready = 1'b0;
      applyStimulus(2);
    end
    checkOutput("tx0 full", 32'(tx_full[0]), 32'h1);
    checkOutput("tx0 head 70", 32'(tx_data[7:0]), 32'h70);
    io_bus.io_output_data  = 8'h77;
    io_bus.io_output_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput("no done while full", 32'(io_bus.io_output_done), 32'h0);
    end
    tx_ready = 2'b01;
    applyStimulus(1);
    checkOutput("no done on freeing edge", 32'(io_bus.io_output_done), 32'h0);
    checkOutput("tx0 not full", 32'(tx_full[0]), 32'h0);
    tx_ready = 2'b00;
    applyStimulus(1);
    checkOutput("done after space", 32'(io_bus.io_output_done), 32'h1);
    io_bus.io_output_ready = 1'b0;
    tx_ready = 2'b01;
    exp_list = '{8'h71, 8'h72, 8'h73, 8'h77};
    for (int k = 0; k < 4; k++) begin
      checkOutput("tx0 drain order", 32'(tx_data[7:0]), 32'(exp_list[k]));
      applyStimulus(1);
    end
    tx_ready = 2'b00;
    checkOutput("tx0 empty", 32'(tx_valid[0]), 32'h0);

    // Out-of-range select, then reset in the middle of the output lockout.
    io_bus.io_ch_sel = 2'd3;
    rx_valid = 2'b01;
    rx_data  = 16'h0033;
    applyStimulus(1);
    rx_valid = 2'b00;
    checkOutput("sel3 input_ready", 32'(io_bus.io_input_ready), 32'h0);
    checkOutput("rx0 buffered", 32'(rx_empty[0]), 32'h0);
    io_bus.io_input_done = 1'b1;
    applyStimulus(1);
    io_bus.io_input_done = 1'b0;
    checkOutput("sel3 no pop", 32'(rx_empty[0]), 32'h0);
    io_bus.io_output_data  = 8'h44;
    io_bus.io_output_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput("sel3 no done", 32'(io_bus.io_output_done), 32'h0);
    end
    io_bus.io_ch_sel = 2'd1;
    applyStimulus(1);
    checkOutput("sel1 accepted", 32'(io_bus.io_output_done), 32'h1);
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("mid reset rx_empty", 32'(rx_empty), 32'h3);
    checkOutput("mid reset tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("mid reset done", 32'(io_bus.io_output_done), 32'h0);
    checkOutput("mid reset rx_ready", 32'(rx_ready), 32'h0);
    rst = 1'b0;
    io_bus.io_output_ready = 1'b0;
    io_bus.io_ch_sel = 2'd0;
    applyStimulus(1);
    checkOutput("post reset rx_ready", 32'(rx_ready), 32'h3);
    checkOutput("post reset rx_empty", 32'(rx_empty), 32'h3);
    checkOutput("post reset tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("post reset input_ready", 32'(io_bus.io_input_ready), 32'h0);
    applyStimulus(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
